// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared 1-8-7 floating-point format constants, FSM states and helpers
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 7;
  localparam int FP_W   = 1 + EXP_W + MANT_W;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int QW     = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  // Exponent and fraction both zero; the sign is ignored so -0 counts as zero.
  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return x[FP_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fpdiv_if.sv
// rtl/fpdiv_if.sv - start/result handshake bundle between a requester and fpdiv
interface fpdiv_if;
  import fp_pkg::*;

  logic            en;
  logic [FP_W-1:0] x1;
  logic [FP_W-1:0] x2;
  logic [FP_W-1:0] y;
  logic            ready;
  logic            busy;

  modport master (output en, x1, x2, input y, ready, busy);
  modport slave  (input en, x1, x2, output y, ready, busy);

endinterface

// File: rtl/fpdiv_iter.sv
// rtl/fpdiv_iter.sv - radix-2 restoring mantissa divider, one quotient bit per clock
module fpdiv_iter
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] a_frac,
  input  logic [MANT_W-1:0] b_frac,
  output logic [QW-1:0]     q,
  output logic              rem_nz,
  output logic              done
);

  localparam logic [3:0] LAST = 4'(QW - 1);

  logic [MANT_W+1:0] r;
  logic [MANT_W:0]   d;
  logic [3:0]        count;
  logic              run;
  logic              ge;
  logic [MANT_W+1:0] r_sub;

  // Trial subtraction; the remainder after restoring is always below d, so its top bit is free for the shift.
  always_comb begin
    ge    = r >= {1'b0, d};
    r_sub = ge ? (r - {1'b0, d}) : r;
  end

  // Load hidden-1 mantissas on start, then shift in one quotient bit per edge until all QW bits are produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      d     <= '0;
      q     <= '0;
      count <= '0;
      run   <= 1'b0;
    end else if (start) begin
      r     <= {1'b0, 1'b1, a_frac};
      d     <= {1'b1, b_frac};
      q     <= '0;
      count <= '0;
      run   <= 1'b1;
    end else if (run) begin
      r     <= {r_sub[MANT_W:0], 1'b0};
      q     <= {q[QW-2:0], ge};
      count <= count + 4'd1;
      if (count == LAST) run <= 1'b0;
    end
  end

  assign rem_nz = r != '0;
  assign done   = run && (count == LAST);

endmodule

// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - sequential 1-8-7 floating-point divider with en/ready handshake
module fpdiv
  import fp_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  fpdiv_if.slave bus
);

  state_t            state, state_n;
  logic [FP_W-1:0]   a, b;
  logic              start;
  logic [QW-1:0]     q;
  logic              rem_nz;
  logic              done;

  logic              s;
  logic signed [9:0] e, e_r;
  logic [7:0]        m, m_fin;
  logic              g, st, inc;
  logic [8:0]        m_r;
  logic [FP_W-1:0]   res;

  assign start    = (state == IDLE) && bus.en;
  assign bus.busy = state != IDLE;

  // Operands are latched only at capture so en during a division cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (start) begin
      a <= bus.x1;
      b <= bus.x2;
    end
  end

  fpdiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_frac (bus.x1[MANT_W-1:0]),
    .b_frac (bus.x2[MANT_W-1:0]),
    .q      (q),
    .rem_nz (rem_nz),
    .done   (done)
  );

  // Normalize on the quotient's integer bit, round to nearest even, then pick the special-case result.
  always_comb begin
    s = a[FP_W-1] ^ b[FP_W-1];
    if (q[QW-1]) begin
      e  = $signed({2'b00, a[FP_W-2:MANT_W]}) - $signed({2'b00, b[FP_W-2:MANT_W]}) + 10'(BIAS);
      m  = q[10:3];
      g  = q[2];
      st = (|q[1:0]) | rem_nz;
    end else begin
      e  = $signed({2'b00, a[FP_W-2:MANT_W]}) - $signed({2'b00, b[FP_W-2:MANT_W]}) + 10'(BIAS - 1);
      m  = q[9:2];
      g  = q[1];
      st = q[0] | rem_nz;
    end
    inc = g & (st | m[0]);
    m_r = {1'b0, m} + {8'd0, inc};
    if (m_r[8]) begin
      m_fin = 8'h80;
      e_r   = e + 10'sd1;
    end else begin
      m_fin = m_r[7:0];
      e_r   = e;
    end
    if (is_zero(b))            res = {s, EXP_MAX, 7'd0};
    else if (is_zero(a))       res = {s, 15'd0};
    else if (e_r >= 10'sd255)  res = {s, EXP_MAX, 7'd0};
    else if (e_r <= 10'sd0)    res = {s, 15'd0};
    else                       res = {s, e_r[7:0], m_fin[6:0]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: capture, iterate until the divider reports its last bit, one normalize cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.en) state_n = DIV;
      DIV:     if (done)   state_n = NORM;
      NORM:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result register and one-cycle ready pulse, both written only when leaving NORM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y     <= '0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= state == NORM;
      if (state == NORM) bus.y <= res;
    end
  end

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - self-checking bench for fpdiv: directed cases, handshake, reset, random vs reference
module tb_fpdiv;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  fpdiv_if bus ();

  fpdiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact integer division of the hidden-1 mantissas, then round-to-nearest-even.
  function automatic logic [15:0] ref_div(input logic [15:0] x1, input logic [15:0] x2);
    logic s;
    int   m1, m2, num, quo, rem, e, sh, kept, low, half;
    s = x1[15] ^ x2[15];
    if (x2[14:0] == 15'd0) return {s, 8'hFF, 7'd0};
    if (x1[14:0] == 15'd0) return {s, 15'd0};
    m1  = 128 + int'(x1[6:0]);
    m2  = 128 + int'(x2[6:0]);
    num = m1 * 1024;
    quo = num / m2;
    rem = num % m2;
    e   = int'(x1[14:7]) - int'(x2[14:7]) + 127;
    if (quo < 1024) begin
      e  = e - 1;
      sh = 2;
    end else begin
      sh = 3;
    end
    kept = quo >> sh;
    low  = quo & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    if (low > half || (low == half && (rem != 0 || (kept % 2) == 1))) kept = kept + 1;
    if (kept == 256) begin
      kept = 128;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 7'd0};
    if (e <= 0)   return {s, 15'd0};
    return {s, e[7:0], kept[6:0]};
  endfunction

  // One division: capture edge, then count edges to ready and cycles with busy high.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.en = 1'b1;
    bus.x1 = a;
    bus.x2 = b;
    @(posedge clk);
    #1;
    bus.en   = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (bus.ready) break;
    end
    res = bus.y;
  endtask

  logic [15:0] res, a, b;
  int          lat, busy_cnt, gap, rdy_cnt;

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    #12;
    check("rst_y", 32'(bus.y), 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h40C0, 16'h4000, res, lat, busy_cnt);
    check("six_by_two", 32'(res), 32'h4040);
    check("latency", 32'(lat), 32'd12);
    check("busy_cycles", 32'(busy_cnt), 32'd12);
    check("busy_low_in_ready", 32'(bus.busy), 32'h0);

    run_op(16'h3F80, 16'h4040, res, lat, busy_cnt);
    check("one_third", 32'(res), 32'h3EAB);
    run_op(16'hC0C0, 16'h4000, res, lat, busy_cnt);
    check("neg_six_by_two", 32'(res), 32'hC040);
    run_op(16'h3F80, 16'h0000, res, lat, busy_cnt);
    check("div_by_zero", 32'(res), 32'h7F80);
    check("div_by_zero_lat", 32'(lat), 32'd12);
    run_op(16'h0000, 16'h4000, res, lat, busy_cnt);
    check("zero_dividend", 32'(res), 32'h0000);
    run_op(16'h8000, 16'h0000, res, lat, busy_cnt);
    check("zero_by_zero", 32'(res), 32'hFF80);
    run_op(16'h7F00, 16'h3E80, res, lat, busy_cnt);
    check("overflow", 32'(res), 32'h7F80);
    run_op(16'h0080, 16'h4000, res, lat, busy_cnt);
    check("underflow", 32'(res), 32'h0000);

    // Handshake: en pulses mid-division are ignored; en in the ready cycle starts the next one.
    @(negedge clk);
    bus.en = 1'b1;
    bus.x1 = 16'h40C0;
    bus.x2 = 16'h4000;
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    rdy_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) rdy_cnt++;
      if (k == 2 || k == 6) begin
        bus.en = 1'b1;
        bus.x1 = 16'h3F80;
        bus.x2 = 16'h4040;
      end else begin
        bus.en = 1'b0;
      end
      if (k == 12) begin
        check("hs_ready_at_t12", 32'(bus.ready), 32'h1);
        check("hs_operands_kept", 32'(bus.y), 32'h4040);
        bus.en = 1'b1;
      end
    end
    check("hs_single_ready", 32'(rdy_cnt), 32'd1);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    check("hs_b2b_busy", 32'(bus.busy), 32'h1);
    gap = 1;
    for (int i = 0; i < 30; i++) begin
      if (bus.ready) break;
      @(posedge clk);
      #1;
      gap++;
    end
    check("hs_b2b_gap", 32'(gap), 32'd13);
    check("hs_b2b_result", 32'(bus.y), 32'h3EAB);

    // Asynchronous reset mid-division.
    @(negedge clk);
    bus.en = 1'b1;
    bus.x1 = 16'h40C0;
    bus.x2 = 16'h4000;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (4) @(posedge clk);
    check("pre_rst_y", 32'(bus.y), 32'h3EAB);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_y", 32'(bus.y), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_ready", 32'(bus.ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) rdy_cnt++;
    end
    check("no_ready_after_rst", 32'(rdy_cnt), 32'd0);
    run_op(16'h3F80, 16'h4040, res, lat, busy_cnt);
    check("post_rst_result", 32'(res), 32'h3EAB);
    check("post_rst_latency", 32'(lat), 32'd12);

    // Random operands against the reference model.
    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 15) == 0) b[14:0] = 15'd0;
      if ($urandom_range(0, 15) == 0) a[14:0] = 15'd0;
      if ($urandom_range(0, 3) == 0) b[14:7] = a[14:7] - 8'($urandom_range(0, 3));
      run_op(a, b, res, lat, busy_cnt);
      check($sformatf("rand_%0d_%h_%h", n, a, b), 32'(res), 32'(ref_div(a, b)));
      if (lat != 12) check($sformatf("rand_lat_%0d", n), 32'(lat), 32'd12);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
